// File: rtl/state_sequencer_if.sv
// Handshake bundle between the board controls and the one-hot display
// sequencer: run/step/clear flow in, seven state lines and tick flow out.
interface state_sequencer_if;
  logic run;
  logic step;
  logic clear;
  logic stateOut_0;
  logic stateOut_1;
  logic stateOut_2;
  logic stateOut_3;
  logic stateOut_4;
  logic stateOut_5;
  logic stateOut_6;
  logic tick;

  // Driver side (keys/switches, or a testbench)
  modport master (
    output run, step, clear,
    input  stateOut_0, stateOut_1, stateOut_2, stateOut_3,
           stateOut_4, stateOut_5, stateOut_6, tick
  );

  // Sequencer side
  modport slave (
    input  run, step, clear,
    output stateOut_0, stateOut_1, stateOut_2, stateOut_3,
           stateOut_4, stateOut_5, stateOut_6, tick
  );
endinterface

// File: rtl/state_sequencer.sv
// One-hot S0..S6 sequencer for the hex display decoder. Advances on a
// dwell timer (while run=1) or on each rising edge of the raw step key,
// S6 wraps to S1, clear returns to S0. Outputs are purely registered and
// any non-one-hot state self-recovers to S0 on the next edge.
module state_sequencer #(
  parameter int DWELL = 50_000_000,  // cycles per state under auto-advance
  parameter int CW    = 26           // dwell counter width, 2^CW > DWELL
) (
  input  logic             clk,
  input  logic             reset,
  state_sequencer_if.slave bus
);

  typedef enum logic [6:0] {
    S0 = 7'b0000001,
    S1 = 7'b0000010,
    S2 = 7'b0000100,
    S3 = 7'b0001000,
    S4 = 7'b0010000,
    S5 = 7'b0100000,
    S6 = 7'b1000000
  } state_e;

  // State kept as a raw vector so an upset into a non-one-hot pattern is
  // representable and can be detected.
  logic [6:0]    state_q, state_d;
  logic [6:0]    adv_state;
  logic          legal;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  logic          sync1_q, sync2_q, prev_q;
  logic          step_edge;
  logic          expire;

  // Two-flop synchronizer for the asynchronous key plus an edge-detect flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= bus.step;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // One request per rising edge, however long the key is held
  assign step_edge = sync2_q & ~prev_q;

  // Timer expiry only counts while running; a paused timer never fires
  assign expire = bus.run && (cnt_q == CW'(DWELL - 1));

  // Successor in the display loop and one-hot legality of the current state
  always_comb begin
    adv_state = S0;
    legal     = 1'b1;
    case (state_q)
      S0:      adv_state = S1;
      S1:      adv_state = S2;
      S2:      adv_state = S3;
      S3:      adv_state = S4;
      S4:      adv_state = S5;
      S5:      adv_state = S6;
      S6:      adv_state = S1;
      default: legal     = 1'b0;
    endcase
  end

  // Next state, dwell counter and tick; recovery > clear > step > timer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (!legal) begin
      state_d = S0;
      cnt_d   = '0;
      tick_d  = 1'b1;
    end else if (bus.clear) begin
      // Clear in S0 is not a state change, so no tick
      state_d = S0;
      cnt_d   = '0;
      tick_d  = (state_q != S0);
    end else if (step_edge || expire) begin
      // A step edge landing on expiry is merged into one advance
      state_d = adv_state;
      cnt_d   = '0;
      tick_d  = 1'b1;
    end else if (bus.run) begin
      cnt_d   = cnt_q + CW'(1);
    end
  end

  // State, dwell counter and tick registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.stateOut_0 = state_q[0];
  assign bus.stateOut_1 = state_q[1];
  assign bus.stateOut_2 = state_q[2];
  assign bus.stateOut_3 = state_q[3];
  assign bus.stateOut_4 = state_q[4];
  assign bus.stateOut_5 = state_q[5];
  assign bus.stateOut_6 = state_q[6];
  assign bus.tick       = tick_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer with DWELL=4: directed scenarios with closed-form
// expectations, then randomized run/step/clear against a state-index model.
module tb_state_sequencer;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  state_sequencer_if bus();

  state_sequencer #(.DWELL(DW), .CW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] so;
  assign so = {bus.stateOut_6, bus.stateOut_5, bus.stateOut_4, bus.stateOut_3,
               bus.stateOut_2, bus.stateOut_1, bus.stateOut_0};

  int nchk = 0;
  int nerr = 0;

  // Reference: state as index 0..6 (-1 = corrupted), dwell count, and the
  // last three samples of the key (two sync stages plus the previous one).
  int m_state, m_cnt;
  bit m_tick;
  bit h1, h2, h3;

  function automatic logic [6:0] oh(int i);
    return 7'(1 << i);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_cnt = 0; m_tick = 0;
    h1 = 0; h2 = 0; h3 = 0;
  endtask

  // One clock of the reference, using the inputs sampled at this edge
  task automatic m_step();
    bit e;
    e = h2 & ~h3;
    if (m_state < 0) begin
      m_state = 0; m_cnt = 0; m_tick = 1;
    end else if (bus.clear) begin
      m_tick = (m_state != 0); m_state = 0; m_cnt = 0;
    end else if (e || (bus.run && m_cnt == DW - 1)) begin
      m_state = m_state % 6 + 1; m_cnt = 0; m_tick = 1;
    end else begin
      m_tick = 0;
      if (bus.run) m_cnt++;
    end
    h3 = h2; h2 = h1; h1 = bus.step;
  endtask

  // Advance one edge, then compare DUT against the model on the falling edge
  task automatic cyc();
    @(posedge clk);
    m_step();
    @(negedge clk);
    chk("state", so, oh(m_state));
    chk("tick", bus.tick, m_tick);
  endtask

  task automatic do_reset();
    reset = 1; bus.run = 0; bus.step = 0; bus.clear = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", so, 7'b0000001);
    chk("rst_tick", bus.tick, 1'b0);
    reset = 0;
    m_reset();
  endtask

  initial begin
    int hold;
    bus.run = 0; bus.step = 0; bus.clear = 0;

    // Auto-advance: S0 for 4 edges, then S1..S6,S1 each for 4; tick every 4th
    do_reset();
    bus.run = 1;
    for (int c = 1; c <= 32; c++) begin
      cyc();
      chk("auto_state", so, oh(c < 4 ? 0 : ((c / 4 - 1) % 6) + 1));
      chk("auto_tick", bus.tick, (c % 4) == 0);
    end

    // Single 3-cycle step pulse with timer frozen: one advance, 2 edges late
    do_reset();
    bus.step = 1;
    cyc(); chk("step_lat0", so, oh(0));
    cyc(); chk("step_lat1", so, oh(0));
    cyc(); chk("step_adv", so, oh(1)); chk("step_tick", bus.tick, 1'b1);
    bus.step = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      chk("step_still", so, oh(1));
      chk("step_notick", bus.tick, 1'b0);
    end

    // Pause run for 5 cycles at cnt=2 in S1: S1 held 9 cycles total
    do_reset();
    bus.run = 1;
    repeat (6) cyc();
    chk("pause_pre", so, oh(1));
    bus.run = 0;
    repeat (5) cyc();
    chk("pause_hold", so, oh(1));
    bus.run = 1;
    cyc(); chk("pause_last", so, oh(1)); chk("pause_last_tick", bus.tick, 1'b0);
    cyc(); chk("pause_adv", so, oh(2)); chk("pause_adv_tick", bus.tick, 1'b1);

    // Step edge coincident with expiry in S2: single advance to S3
    do_reset();
    bus.run = 1;
    repeat (9) cyc();
    bus.step = 1;
    cyc(); cyc(); cyc();
    chk("coin_adv", so, oh(3)); chk("coin_tick", bus.tick, 1'b1);
    bus.step = 0;
    repeat (3) cyc();
    chk("coin_hold", so, oh(3));
    cyc(); chk("coin_next", so, oh(4)); chk("coin_next_tick", bus.tick, 1'b1);

    // Clear together with a step edge in S5, then clear while in S0
    do_reset();
    bus.run = 1;
    repeat (19) cyc();
    bus.step = 1;
    cyc(); chk("clr_in_s5", so, oh(5));
    cyc();
    bus.clear = 1;
    cyc(); chk("clr_s0", so, oh(0)); chk("clr_tick", bus.tick, 1'b1);
    cyc(); chk("clr_idle", so, oh(0)); chk("clr_idle_tick", bus.tick, 1'b0);
    bus.clear = 0; bus.step = 0;
    repeat (4) cyc();

    // Asynchronous reset mid-dwell in S4, visible before the next edge
    do_reset();
    bus.run = 1;
    repeat (17) cyc();
    chk("arst_pre", so, oh(4));
    #2 reset = 1;
    #1;
    chk("arst_state", so, 7'b0000001);
    chk("arst_tick", bus.tick, 1'b0);
    @(negedge clk);
    reset = 0;
    m_reset();
    bus.run = 0;
    repeat (2) cyc();

    // Corrupt the state register to a two-hot pattern: recovers to S0 + tick
    force dut.state_q = 7'b0000110;
    #1 release dut.state_q;
    m_state = -1;
    cyc();
    chk("recov_state", so, oh(0));
    chk("recov_tick", bus.tick, 1'b1);
    cyc();
    chk("recov_quiet", bus.tick, 1'b0);

    // Randomized run/step/clear against the model
    do_reset();
    hold = 1;
    for (int c = 0; c < 3000; c++) begin
      bus.run = ($urandom_range(0, 9) != 0);
      bus.clear = ($urandom_range(0, 79) == 0);
      hold--;
      if (hold <= 0) begin
        bus.step = ~bus.step;
        hold = $urandom_range(1, 6);
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
